// File: rtl/spi_pkg.sv
// Shared types and constants for the multi-slave SPI master slot.
package spi_pkg;

  // Transfer sequencer states: idle, first half-bit, second half-bit.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_P0   = 2'd1,
    ST_P1   = 2'd2
  } spi_state_t;

  // Register word addresses (only addr[1:0] is decoded).
  localparam logic [1:0]  ADDR_SS    = 2'd1;
  localparam logic [1:0]  ADDR_DATA  = 2'd2;
  localparam logic [1:0]  ADDR_CTRL  = 2'd3;

  // Half-period divisor loaded at reset.
  localparam logic [15:0] DVSR_RESET = 16'd199;

  // Serial clock level for a given state: cpol when idle, otherwise
  // the phase-adjusted level that flips between the two half-bits.
  function automatic logic sclk_level(input spi_state_t st,
                                      input logic       cpol,
                                      input logic       cpha);
    logic lvl;
    case (st)
      ST_P0:   lvl = cpol ^ cpha;
      ST_P1:   lvl = cpol ^ cpha ^ 1'b1;
      default: lvl = cpol;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// Serial engine: sequencer, half-period and bit counters, shifter,
// receive buffer and the ready/done status flags.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] tx_data,
  input  logic [15:0]  dvsr,
  input  logic         cpol,
  input  logic         cpha,
  input  logic         lsb_first,
  input  logic         miso,
  output logic         sclk,
  output logic         mosi,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] rx_data
);

  spi_state_t   state_r;
  logic [15:0]  half_cnt_r;
  logic [4:0]   bit_cnt_r;
  logic [W-1:0] shift_r;
  logic         miso_bit_r;
  logic         ready_r;
  logic         done_r;
  logic [W-1:0] rx_data_r;

  logic         half_end_s;
  logic         last_bit_s;
  logic [W-1:0] shift_next_s;

  // Half-bit end, last-bit detect and the shifter's next value; the bit
  // sampled at the end of P0 enters on the side opposite the output bit.
  always_comb begin
    half_end_s = (half_cnt_r == dvsr);
    last_bit_s = (bit_cnt_r == 5'(W - 1));
    if (lsb_first) begin
      shift_next_s = {miso_bit_r, shift_r[W-1:1]};
    end else begin
      shift_next_s = {shift_r[W-2:0], miso_bit_r};
    end
  end

  // Pin levels decoded from registered state; mosi is held low while idle.
  always_comb begin
    sclk = sclk_level(state_r, cpol, cpha);
    if (state_r == ST_IDLE) begin
      mosi = 1'b0;
    end else if (lsb_first) begin
      mosi = shift_r[0];
    end else begin
      mosi = shift_r[W-1];
    end
  end

  // Transfer sequencer with its counters, shifter and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      half_cnt_r <= 16'd0;
      bit_cnt_r  <= 5'd0;
      shift_r    <= '0;
      miso_bit_r <= 1'b0;
      ready_r    <= 1'b1;
      done_r     <= 1'b0;
      rx_data_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r    <= ST_P0;
            half_cnt_r <= 16'd0;
            bit_cnt_r  <= 5'd0;
            shift_r    <= tx_data;
            ready_r    <= 1'b0;
            done_r     <= 1'b0;
          end
        end
        ST_P0: begin
          if (half_end_s) begin
            half_cnt_r <= 16'd0;
            miso_bit_r <= miso;
            state_r    <= ST_P1;
          end else begin
            half_cnt_r <= half_cnt_r + 16'd1;
          end
        end
        ST_P1: begin
          if (half_end_s) begin
            half_cnt_r <= 16'd0;
            shift_r    <= shift_next_s;
            if (last_bit_s) begin
              state_r   <= ST_IDLE;
              rx_data_r <= shift_next_s;
              ready_r   <= 1'b1;
              done_r    <= 1'b1;
            end else begin
              bit_cnt_r <= bit_cnt_r + 5'd1;
              state_r   <= ST_P0;
            end
          end else begin
            half_cnt_r <= half_cnt_r + 16'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready   = ready_r;
  assign done    = done_r;
  assign rx_data = rx_data_r;

endmodule

// File: rtl/spi_multi_core.sv
// SPI master slot: register decode, configuration registers and slave
// selects around a single shift engine.
module spi_multi_core
  import spi_pkg::*;
#(
  parameter int W = 8,
  parameter int S = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cs,
  input  logic         read,
  input  logic         write,
  input  logic [4:0]   addr,
  input  logic [31:0]  wr_data,
  output logic [31:0]  rd_data,
  output logic         spi_sclk,
  output logic         spi_mosi,
  input  logic         spi_miso,
  output logic [S-1:0] spi_ss_n
);

  logic [S-1:0] ss_n_r;
  logic [15:0]  dvsr_r;
  logic         cpol_r;
  logic         cpha_r;
  logic         lsb_first_r;

  logic         ready_s;
  logic         done_s;
  logic [W-1:0] rx_data_s;
  logic         ss_wr_s;
  logic         data_wr_s;
  logic         ctrl_wr_s;
  logic         unused_s;

  // Reads have no side effects, so the read strobe and upper address bits
  // are intentionally left undecoded.
  assign unused_s = ^{read, addr[4:2], wr_data};

  // Write decode; DATA and CTRL are locked out while a frame is in flight
  // so configuration cannot change underneath the engine.
  always_comb begin
    ss_wr_s   = cs & write & (addr[1:0] == ADDR_SS);
    data_wr_s = cs & write & (addr[1:0] == ADDR_DATA) & ready_s;
    ctrl_wr_s = cs & write & (addr[1:0] == ADDR_CTRL) & ready_s;
  end

  // Slave-select and configuration registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_n_r      <= '1;
      dvsr_r      <= DVSR_RESET;
      cpol_r      <= 1'b0;
      cpha_r      <= 1'b0;
      lsb_first_r <= 1'b0;
    end else begin
      if (ss_wr_s) begin
        ss_n_r <= wr_data[S-1:0];
      end
      if (ctrl_wr_s) begin
        dvsr_r      <= wr_data[15:0];
        cpol_r      <= wr_data[16];
        cpha_r      <= wr_data[17];
        lsb_first_r <= wr_data[18];
      end
    end
  end

  // Status word; for W above 30 the flags overlay the top data bits.
  always_comb begin
    rd_data          = 32'd0;
    rd_data[W-1:0]   = rx_data_s;
    rd_data[30]      = done_s;
    rd_data[31]      = ready_s;
  end

  spi_shift_engine #(
    .W (W)
  ) u_engine (
    .clk       (clk),
    .reset     (reset),
    .start     (data_wr_s),
    .tx_data   (wr_data[W-1:0]),
    .dvsr      (dvsr_r),
    .cpol      (cpol_r),
    .cpha      (cpha_r),
    .lsb_first (lsb_first_r),
    .miso      (spi_miso),
    .sclk      (spi_sclk),
    .mosi      (spi_mosi),
    .ready     (ready_s),
    .done      (done_s),
    .rx_data   (rx_data_s)
  );

  assign spi_ss_n = ss_n_r;

endmodule

// File: tb/tb_spi_multi_core.sv
// Directed bench: instance A (W=8, S=4, miso looped to mosi) and
// instance B (W=16, S=1, mode-3 slave model returning 0xBEEF).
module tb_spi_multi_core;

  logic        clk = 1'b0;
  logic        reset;

  logic        cs_a, read_a, write_a;
  logic [4:0]  addr_a;
  logic [31:0] wr_data_a, rd_data_a;
  logic        spi_sclk_a, spi_mosi_a, spi_miso_a;
  logic [3:0]  spi_ss_n_a;

  logic        cs_b, read_b, write_b;
  logic [4:0]  addr_b;
  logic [31:0] wr_data_b, rd_data_b;
  logic        spi_sclk_b, spi_mosi_b;
  logic        spi_miso_b = 1'b0;
  logic [0:0]  spi_ss_n_b;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          ncyc;
  int          c0;
  int          guard;
  logic [31:0] sclk_tr, mosi_tr;

  logic        slave_en = 1'b0;
  int          slave_idx = 0;
  logic [15:0] slave_tx = 16'hBEEF;
  logic [15:0] slave_rx = 16'h0000;

  spi_multi_core #(.W(8), .S(4)) dut_a (
    .clk(clk), .reset(reset), .cs(cs_a), .read(read_a), .write(write_a),
    .addr(addr_a), .wr_data(wr_data_a), .rd_data(rd_data_a),
    .spi_sclk(spi_sclk_a), .spi_mosi(spi_mosi_a), .spi_miso(spi_miso_a),
    .spi_ss_n(spi_ss_n_a)
  );

  spi_multi_core #(.W(16), .S(1)) dut_b (
    .clk(clk), .reset(reset), .cs(cs_b), .read(read_b), .write(write_b),
    .addr(addr_b), .wr_data(wr_data_b), .rd_data(rd_data_b),
    .spi_sclk(spi_sclk_b), .spi_mosi(spi_mosi_b), .spi_miso(spi_miso_b),
    .spi_ss_n(spi_ss_n_b)
  );

  assign spi_miso_a = spi_mosi_a;

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter advanced on every active edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Mode-3 slave: present the next reply bit on each leading (falling) edge.
  always @(negedge spi_sclk_b) begin
    if (slave_en && slave_idx < 16) begin
      spi_miso_b <= slave_tx[15 - slave_idx];
      slave_idx  <= slave_idx + 1;
    end
  end

  // Mode-3 slave: capture master data on each trailing (rising) edge.
  always @(posedge spi_sclk_b) begin
    if (slave_en) slave_rx <= {slave_rx[14:0], spi_mosi_b};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bus writes: called at a negedge, strobe for one active edge, return at the next negedge.
  task automatic bus_a(input logic [1:0] a, input logic [31:0] d);
    cs_a = 1'b1; write_a = 1'b1; addr_a = {3'b101, a}; wr_data_a = d;
    @(negedge clk);
    cs_a = 1'b0; write_a = 1'b0; addr_a = 5'd0; wr_data_a = 32'd0;
  endtask

  task automatic bus_b(input logic [1:0] a, input logic [31:0] d);
    cs_b = 1'b1; write_b = 1'b1; addr_b = {3'b010, a}; wr_data_b = d;
    @(negedge clk);
    cs_b = 1'b0; write_b = 1'b0; addr_b = 5'd0; wr_data_b = 32'd0;
  endtask

  // Start a frame on A and wait (bounded) for ready, tracing sclk/mosi per cycle.
  task automatic run_a(input logic [31:0] d, output int n, output logic [31:0] s_tr,
                       output logic [31:0] m_tr);
    bus_a(2'd2, d);
    n = 0; s_tr = 32'd0; m_tr = 32'd0;
    while (rd_data_a[31] !== 1'b1 && n < 4000) begin
      if (n < 32) begin
        s_tr[n] = spi_sclk_a;
        m_tr[n] = spi_mosi_a;
      end
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    cs_a = 1'b0; read_a = 1'b0; write_a = 1'b0; addr_a = 5'd0; wr_data_a = 32'd0;
    cs_b = 1'b0; read_b = 1'b0; write_b = 1'b0; addr_b = 5'd0; wr_data_b = 32'd0;
    #1;
    check("reset_rd_a",   rd_data_a, 32'h8000_0000);
    check("reset_ss_a",   {28'd0, spi_ss_n_a}, 32'h0000_000F);
    check("reset_sclk_a", {31'd0, spi_sclk_a}, 32'd0);
    check("reset_mosi_a", {31'd0, spi_mosi_a}, 32'd0);
    check("reset_rd_b",   rd_data_b, 32'h8000_0000);
    check("reset_sclk_b", {31'd0, spi_sclk_b}, 32'd0);
    check("reset_ss_b",   {31'd0, spi_ss_n_b}, 32'd1);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Default divisor 199: 2*200*8 cycles.
    run_a(32'h0000_005A, ncyc, sclk_tr, mosi_tr);
    check("dflt_dvsr_cycles", ncyc, 32'd3200);
    check("dflt_dvsr_rd",     rd_data_a, 32'hC000_005A);

    // Mode 0, dvsr=1, slave select 0xE one cycle after the write.
    bus_a(2'd3, 32'h0000_0001);
    check("ss_before_wr", {28'd0, spi_ss_n_a}, 32'h0000_000F);
    bus_a(2'd1, 32'h0000_000E);
    check("ss_after_wr_e", {28'd0, spi_ss_n_a}, 32'h0000_000E);
    run_a(32'h0000_00A5, ncyc, sclk_tr, mosi_tr);
    check("m0_ready_low", ncyc, 32'd32);
    check("m0_sclk_trace", sclk_tr, 32'hCCCC_CCCC);
    check("m0_mosi_trace", mosi_tr, 32'hF0F0_0F0F);
    check("m0_rd",         rd_data_a, 32'hC000_00A5);

    // LSB first, data 0x01: only bit slot 0 drives a 1.
    bus_a(2'd3, 32'h0004_0001);
    run_a(32'h0000_0001, ncyc, sclk_tr, mosi_tr);
    check("lsb_ready_low",  ncyc, 32'd32);
    check("lsb_mosi_trace", mosi_tr, 32'h0000_000F);
    check("lsb_sclk_trace", sclk_tr, 32'hCCCC_CCCC);
    check("lsb_rd",         rd_data_a, 32'hC000_0001);

    // DATA and CTRL writes mid-frame are ignored.
    bus_a(2'd3, 32'h0000_0001);
    bus_a(2'd2, 32'h0000_003C);
    c0 = cyc;
    check("busy_flags", {30'd0, rd_data_a[31:30]}, 32'd0);
    @(negedge clk); @(negedge clk);
    bus_a(2'd2, 32'h0000_00FF);
    bus_a(2'd3, 32'h0000_0005);
    guard = 0;
    while (rd_data_a[31] !== 1'b1 && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    check("ignore_wr_cycles", cyc - c0, 32'd32);
    check("ignore_wr_rd",     rd_data_a, 32'hC000_003C);

    // DATA write on the completion cycle is ignored.
    bus_a(2'd2, 32'h0000_0069);
    c0 = cyc;
    guard = 0;
    while (cyc != c0 + 31 && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    check("cmpl_ready_low", {31'd0, rd_data_a[31]}, 32'd0);
    bus_a(2'd2, 32'h0000_0011);
    check("cmpl_wr_rd", rd_data_a, 32'hC000_0069);
    @(negedge clk);
    check("cmpl_wr_rd_next", rd_data_a, 32'hC000_0069);

    // Slave-select write during a transfer.
    bus_a(2'd2, 32'h0000_0096);
    check("ss_mid_before", {28'd0, spi_ss_n_a}, 32'h0000_000E);
    bus_a(2'd1, 32'h0000_0007);
    check("ss_mid_after", {28'd0, spi_ss_n_a}, 32'h0000_0007);
    guard = 0;
    while (rd_data_a[31] !== 1'b1 && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    check("ss_mid_rd", rd_data_a, 32'hC000_0096);

    // Asynchronous reset during bit 3 (second half, sclk high).
    bus_a(2'd2, 32'h0000_00A5);
    for (int i = 0; i < 14; i++) @(negedge clk);
    check("bit3_sclk_high", {31'd0, spi_sclk_a}, 32'd1);
    check("bit3_busy",      {31'd0, rd_data_a[31]}, 32'd0);
    #2 reset = 1'b1;
    #1;
    check("arst_ss",   {28'd0, spi_ss_n_a}, 32'h0000_000F);
    check("arst_sclk", {31'd0, spi_sclk_a}, 32'd0);
    check("arst_mosi", {31'd0, spi_mosi_a}, 32'd0);
    check("arst_rd",   rd_data_a, 32'h8000_0000);
    #1 reset = 1'b0;
    @(negedge clk);

    // Instance B: mode 3, W=16, slave replies 0xBEEF.
    bus_b(2'd3, 32'h0003_0001);
    check("m3_idle_before", {31'd0, spi_sclk_b}, 32'd1);
    slave_en = 1'b1;
    bus_b(2'd2, 32'h0000_1234);
    ncyc = 0;
    while (rd_data_b[31] !== 1'b1 && ncyc < 500) begin
      ncyc++;
      @(negedge clk);
    end
    check("m3_cycles",     ncyc, 32'd64);
    check("m3_idle_after", {31'd0, spi_sclk_b}, 32'd1);
    check("m3_rd",         rd_data_b, 32'hC000_BEEF);
    check("m3_slave_rx",   {16'd0, slave_rx}, 32'h0000_1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_multi_core.md
SPI_MULTI_CORE -- requirements
Module: spi_multi_core

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning SPI frame width in bits, legal range 4..32.
REQ-002 The block SHALL have parameter S, default 1, meaning the number of slave-select lines, legal range 1..8.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows: clk  in  1  system clock, all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cs  in  1  slot select.
REQ-006 read  in  1  read strobe, qualified by cs.
REQ-007 write  in  1  write strobe, qualified by cs.
REQ-008 addr  in  5  slot word address; only addr[1:0] is decoded.
REQ-009 wr_data  in  32  write data.
REQ-010 rd_data  out  32  read data.
REQ-011 spi_sclk  out  1  serial clock.
REQ-012 spi_mosi  out  1  master data out.
REQ-013 spi_miso  in  1  slave data in.
REQ-014 spi_ss_n  out  S  active-low slave selects.

Function
REQ-015 Register map writes SHALL be: addr 1 = SS (wr_data[S-1:0] -> ss_n register); addr 2 = DATA (wr_data[W-1:0] loads the shifter and starts a transfer); addr 3 = CTRL (wr_data[15:0] = dvsr, bit16 = cpol, bit17 = cpha, bit18 = lsb_first).
REQ-016 rd_data SHALL be combinational for any addr: [W-1:0] = rx_data, bit30 = done, bit31 = ready, all other bits 0.
REQ-017 The FSM SHALL have exactly three states: IDLE, P0 (first half-bit), P1 (second half-bit).
REQ-018 In IDLE, a DATA write SHALL go to P0 on the next edge, clear the half-period and bit counters, deassert ready, and clear done.
REQ-019 Each of P0 and P1 SHALL last dvsr+1 clk cycles; a whole transfer SHALL last exactly 2*(dvsr+1)*W cycles.
REQ-020 spi_sclk SHALL equal cpol in IDLE, and cpol XOR cpha XOR (state==P1) in P0 and P1.
REQ-021 spi_miso SHALL be sampled into the shifter on the last cycle of P0; the shifter SHALL advance on the last cycle of P1.
REQ-022 Bit order SHALL be MSB first; lsb_first=1 SHALL select LSB first.
REQ-023 spi_mosi SHALL present the current output bit from the first cycle of P0 and hold it through P1.
REQ-024 On the last cycle of P1 for bit W-1, the block SHALL go to IDLE, copy the shifter to rx_data, set ready=1, and set done=1 (sticky).
REQ-025 A DATA or CTRL write while not ready SHALL be ignored; an SS write SHALL take effect on the next edge in any state.
REQ-026 dvsr=0 SHALL be legal and SHALL give sclk = clk/2.
REQ-027 A simultaneous completion and DATA write in the same cycle SHALL ignore the write, because ready is still 0 in that cycle.

Reset
REQ-028 Reset SHALL be asynchronous and active-high, and SHALL abort any transfer to IDLE.
REQ-029 Reset values SHALL be: ready=1, done=0, rx_data=0, ss_n all 1, cpol=0, cpha=0, lsb_first=0, dvsr=199.
REQ-030 Outputs during reset SHALL be: spi_sclk=0, spi_mosi=0.

Structure
REQ-031 Package spi_pkg SHALL hold the state enum and the register address constants (SS=1, DATA=2, CTRL=3).
REQ-032 The block SHALL contain one sub-module, spi_shift_engine, holding the FSM, counters, and shifter, and driving sclk/mosi/ready.
REQ-033 Register decode SHALL stay in spi_multi_core.

Verification
REQ-034 Scenario: W=8, dvsr=1, mode 0, DATA=0xA5, miso looped to mosi -> 8 sclk periods of 4 clk each; ready low for 32 cycles; rx_data=0xA5; done=1.
REQ-035 Scenario: mode 3 (cpol=1, cpha=1), W=16, DATA=0x1234, slave model returns 0xBEEF -> sclk idles high before and after; rx_data=0xBEEF.
REQ-036 Scenario: lsb_first=1, W=8, DATA=0x01 -> mosi is 1 in bit slot 0 and 0 in slots 1-7.
REQ-037 Scenario: second DATA write of 0xFF mid-transfer, followed by a CTRL write of dvsr=5 -> both ignored; first frame completes unchanged with original timing.
REQ-038 Scenario: reset asserted at bit 3 -> ss_n=all 1, sclk=0, ready=1, done=0 immediately, without waiting for a clk edge.
REQ-039 Scenario: S=4, SS write 0xE, then 0x7 during a transfer -> spi_ss_n follows 4'b1110 then 4'b0111 one cycle after each write.
